// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction memory loader
package imem_loader_pkg;

  // Halfword width shared with the CPU instruction memory interface
  localparam int HW_W = 16;

  // Default frame start word
  localparam logic [HW_W-1:0] MAGIC_DEFAULT = 16'hA55A;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_COUNT = 3'd2,
    ST_DATA  = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_t;

endpackage

// File: rtl/imem_loader_wr_stage.sv
// rtl/imem_loader_wr_stage.sv - registered memory write port with auto-incrementing address
module imem_loader_wr_stage #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_base,
  input  logic [AW-1:0] base,
  input  logic          wr_en,
  input  logic [DW-1:0] wdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we
);

  logic [AW-1:0] cur_addr;

  // Present each accepted halfword one cycle later and step the address; wraps naturally at the top
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_addr  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      mem_we <= wr_en;
      if (load_base) begin
        cur_addr <= base;
      end else if (wr_en) begin
        cur_addr  <= cur_addr + 1'b1;
        mem_addr  <= cur_addr;
        mem_wdata <= wdata;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed halfword stream to instruction memory loader; optional checksum via IMEM_LOADER_CSUM_EN
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [15:0] MAGIC = MAGIC_DEFAULT,
  parameter int          AW    = 16,
  parameter int          DW    = HW_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          start,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  state_t        state;
  state_t        state_nxt;
  logic          acc;
  logic [DW-1:0] count;
`ifdef IMEM_LOADER_CSUM_EN
  logic [DW-1:0] sum;
`endif

  assign acc = in_valid && in_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode; the end of the payload goes to CSUM or straight to DONE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (acc && (in_data == DW'(MAGIC))) state_nxt = ST_ADDR;
      ST_ADDR:  if (acc) state_nxt = ST_COUNT;
      ST_COUNT: begin
        if (acc) begin
`ifdef IMEM_LOADER_CSUM_EN
          state_nxt = (in_data == '0) ? ST_CSUM : ST_DATA;
`else
          state_nxt = (in_data == '0) ? ST_DONE : ST_DATA;
`endif
        end
      end
      ST_DATA: begin
        if (acc && (count == DW'(1))) begin
`ifdef IMEM_LOADER_CSUM_EN
          state_nxt = ST_CSUM;
`else
          state_nxt = ST_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      ST_CSUM:  if (acc) state_nxt = (in_data == sum) ? ST_DONE : ST_ERROR;
`endif
      ST_DONE:  if (start) state_nxt = ST_IDLE;
      ST_ERROR: if (start) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the registered state, so status changes the cycle after the deciding accept
  always_comb begin
    in_ready = (state != ST_DONE) && (state != ST_ERROR);
    done     = (state == ST_DONE);
    cpu_hold = (state != ST_DONE);
`ifdef IMEM_LOADER_CSUM_EN
    err      = (state == ST_ERROR);
`else
    err      = 1'b0;
`endif
  end

  // Remaining halfword count and running checksum
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      sum   <= '0;
`endif
    end else if (acc && (state == ST_COUNT)) begin
      count <= in_data;
`ifdef IMEM_LOADER_CSUM_EN
      sum   <= '0;
`endif
    end else if (acc && (state == ST_DATA)) begin
      count <= count - 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
      sum   <= sum + in_data;
`endif
    end
  end

  imem_loader_wr_stage #(
    .AW(AW),
    .DW(DW)
  ) u_wr_stage (
    .clk      (clk),
    .rst      (rst),
    .load_base(acc && (state == ST_ADDR)),
    .base     (AW'(in_data)),
    .wr_en    (acc && (state == ST_DATA)),
    .wdata    (in_data),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we)
  );

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        start = 1'b0;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  int nw     = 0;
  int bad_we = 0;
  logic acc_q = 1'b0;
  logic [15:0] wa [64];
  logic [15:0] wd [64];
  int          wc [64];
  int          b;

  imem_loader dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .start    (start),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every write; a write not preceded by an accept is flagged
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (!acc_q) bad_we <= bad_we + 1;
      wa[nw % 64] <= mem_addr;
      wd[nw % 64] <= mem_wdata;
      wc[nw % 64] <= cyc;
      nw <= nw + 1;
    end
    acc_q <= in_valid && in_ready;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic gap();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    in_data  = w;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Base 0, four words 1..4; checksum word only exists in the checksum build
  task automatic nominal_frame(input logic [15:0] csum, input bit stall);
    logic [15:0] fr [7];
    fr = '{16'hA55A, 16'h0000, 16'h0004, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
    for (int i = 0; i < 7; i++) begin
      send(fr[i]);
      if (stall) gap();
    end
`ifdef IMEM_LOADER_CSUM_EN
    send(csum);
`else
    if (csum == 16'hFFFF) gap();
`endif
  endtask

  task automatic chk_nominal_writes(input int base_idx, input bit consec);
    chk("nom_nwrites", nw - base_idx, 4);
    for (int i = 0; i < 4; i++) begin
      chk("nom_addr", {16'h0, wa[(base_idx + i) % 64]}, i);
      chk("nom_data", {16'h0, wd[(base_idx + i) % 64]}, i + 1);
      if (consec) chk("nom_consec", wc[(base_idx + i) % 64], wc[base_idx % 64] + i);
    end
  endtask

  initial begin
    #1 rst = 1'b0;
    gap();
    chk("rst_state", {29'h0, dut.state}, {29'h0, ST_IDLE});
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b1;
    gap();
    chk("idle_ready", in_ready, 1);

    // Nominal load
    b = nw;
    nominal_frame(16'h000A, 1'b0);
    gap();
    chk_nominal_writes(b, 1'b1);
    chk("nom_done", done, 1);
    chk("nom_hold", cpu_hold, 0);
    chk("nom_err", err, 0);
    chk("nom_ready", in_ready, 0);
    pulse_start();
    chk("rearm_done", done, 0);
    chk("rearm_hold", cpu_hold, 1);
    chk("rearm_ready", in_ready, 1);

`ifdef IMEM_LOADER_CSUM_EN
    // Bad checksum
    b = nw;
    nominal_frame(16'h000B, 1'b0);
    gap();
    chk_nominal_writes(b, 1'b1);
    chk("bad_err", err, 1);
    chk("bad_done", done, 0);
    chk("bad_hold", cpu_hold, 1);
    chk("bad_ready", in_ready, 0);
    pulse_start();
    chk("bad_rearm_err", err, 0);
    chk("bad_rearm_hold", cpu_hold, 1);
`endif

    // Junk words and stalls
    b = nw;
    send(16'h1234);
    gap();
    send(16'hFFFF);
    gap();
    chk("junk_state", {29'h0, dut.state}, {29'h0, ST_IDLE});
    nominal_frame(16'h000A, 1'b1);
    gap();
    chk_nominal_writes(b, 1'b0);
    chk("junk_done", done, 1);
    chk("junk_hold", cpu_hold, 0);
    chk("junk_bad_we", bad_we, 0);
    pulse_start();

    // Address wrap
    b = nw;
    send(16'hA55A); send(16'hFFFE); send(16'h0003);
    send(16'h0011); send(16'h0022); send(16'h0033);
`ifdef IMEM_LOADER_CSUM_EN
    send(16'h0066);
`endif
    gap();
    chk("wrap_nwrites", nw - b, 3);
    chk("wrap_a0", wa[b % 64], 16'hFFFE);
    chk("wrap_a1", wa[(b + 1) % 64], 16'hFFFF);
    chk("wrap_a2", wa[(b + 2) % 64], 16'h0000);
    chk("wrap_d2", wd[(b + 2) % 64], 16'h0033);
    chk("wrap_done", done, 1);
    pulse_start();

    // Zero count
    b = nw;
    send(16'hA55A); send(16'h0100); send(16'h0000);
`ifdef IMEM_LOADER_CSUM_EN
    chk("zero_early_done", done, 0);
    send(16'h0000);
`endif
    chk("zero_done", done, 1);
    gap();
    chk("zero_nwrites", nw - b, 0);
    chk("zero_hold", cpu_hold, 0);
    pulse_start();

    // Reset mid-load
    send(16'hA55A); send(16'h0000); send(16'h0004);
    send(16'h0001); send(16'h0002);
    rst = 1'b0;
    #1;
    chk("mid_hold", cpu_hold, 1);
    chk("mid_done", done, 0);
    chk("mid_we", mem_we, 0);
    chk("mid_state", {29'h0, dut.state}, {29'h0, ST_IDLE});
    gap();
    rst = 1'b1;
    gap();
    b = nw;
    nominal_frame(16'h000A, 1'b0);
    gap();
    chk_nominal_writes(b, 1'b1);
    chk("reload_done", done, 1);
    chk("reload_hold", cpu_hold, 0);
    chk("final_bad_we", bad_we, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
